// File: rtl/hack_mux_pkg.sv
// rtl/hack_mux_pkg.sv - shared HACK datapath mux constants and channel index width helper
package hack_mux_pkg;

   localparam int HACK_WORD_W  = 16;
   localparam int HACK_MUX_NCH = 8;

   // Index width for n channels; a single channel still needs one bit of index.
   function automatic int chan_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, search starts one past ptr and wraps
module rr_arbiter
   import hack_mux_pkg::*;
#(
   parameter int NCH = HACK_MUX_NCH
) (
   input  logic [NCH-1:0]             req,
   input  logic [chan_idx_w(NCH)-1:0] ptr,
   input  logic                       en,
   output logic [NCH-1:0]             grant,
   output logic [chan_idx_w(NCH)-1:0] grant_idx
);

   localparam int SELW = chan_idx_w(NCH);

   int   idx;
   logic found;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = 0;
      for (int k = 1; k <= NCH; k++) begin
         idx = (int'(ptr) + k) % NCH;
         if (en && !found && req[idx]) begin
            grant[idx] = 1'b1;
            grant_idx  = SELW'(idx);
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/arb_mux_n.sv
// rtl/arb_mux_n.sv - registered N-way round-robin stream mux with one-entry output register
// Optional MUX_ARB_FORCE_EN adds force_en/force_sel to pin the grant to a single channel.
module arb_mux_n
   import hack_mux_pkg::*;
#(
   parameter int WIDTH = HACK_WORD_W,
   parameter int NCH   = HACK_MUX_NCH,
   parameter int SELW  = chan_idx_w(NCH)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NCH*WIDTH-1:0] in_data,
   input  logic [NCH-1:0]       in_valid,
   output logic [NCH-1:0]       in_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic [SELW-1:0]      out_chan,
   output logic                 out_valid,
   input  logic                 out_ready
`ifdef MUX_ARB_FORCE_EN
   ,
   input  logic                 force_en,
   input  logic [SELW-1:0]      force_sel
`endif
);

   logic             load;
   logic             forced;
   logic [NCH-1:0]   rr_grant;
   logic [SELW-1:0]  rr_idx;
   logic [NCH-1:0]   grant;
   logic [SELW-1:0]  grant_idx;
   logic [WIDTH-1:0] win_data;

   logic [WIDTH-1:0] out_data_q,  out_data_d;
   logic [SELW-1:0]  out_chan_q,  out_chan_d;
   logic             out_valid_q, out_valid_d;
   logic [SELW-1:0]  ptr_q,       ptr_d;

   assign load = !out_valid_q || out_ready;

   rr_arbiter #(.NCH(NCH)) u_arb (
      .req       (in_valid),
      .ptr       (ptr_q),
      .en        (load && !forced && !reset),
      .grant     (rr_grant),
      .grant_idx (rr_idx)
   );

`ifdef MUX_ARB_FORCE_EN
   assign forced = force_en;

   // Out-of-range force_sel never matches a channel, so it yields no grant.
   always_comb begin
      grant     = rr_grant;
      grant_idx = rr_idx;
      if (force_en) begin
         grant     = '0;
         grant_idx = '0;
         for (int i = 0; i < NCH; i++) begin
            if (load && !reset && force_sel == SELW'(i) && in_valid[i]) begin
               grant[i]  = 1'b1;
               grant_idx = SELW'(i);
            end
         end
      end
   end
`else
   assign forced    = 1'b0;
   assign grant     = rr_grant;
   assign grant_idx = rr_idx;
`endif

   always_comb begin
      win_data = '0;
      for (int i = 0; i < NCH; i++) begin
         if (grant[i]) win_data = in_data[i*WIDTH +: WIDTH];
      end
   end

   assign in_ready = grant;

   always_comb begin
      out_data_d  = out_data_q;
      out_chan_d  = out_chan_q;
      out_valid_d = out_valid_q;
      ptr_d       = ptr_q;
      if (load) begin
         out_valid_d = |grant;
         if (|grant) begin
            out_data_d = win_data;
            out_chan_d = grant_idx;
            if (!forced) ptr_d = grant_idx;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_data_q  <= '0;
         out_chan_q  <= '0;
         out_valid_q <= 1'b0;
         ptr_q       <= SELW'(NCH - 1);
      end else begin
         out_data_q  <= out_data_d;
         out_chan_q  <= out_chan_d;
         out_valid_q <= out_valid_d;
         ptr_q       <= ptr_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_chan  = out_chan_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_arb_mux_n.sv
// tb/tb_arb_mux_n.sv - directed and randomized bench for arb_mux_n against a priority-distance model
module tb_arb_mux_n;

   localparam int W    = 16;
   localparam int NCH  = 8;
   localparam int SELW = 3;

   logic               clk;
   logic               reset;
   logic [NCH*W-1:0]   in_data;
   logic [NCH-1:0]     in_valid;
   logic [NCH-1:0]     in_ready;
   logic [W-1:0]       out_data;
   logic [SELW-1:0]    out_chan;
   logic               out_valid;
   logic               out_ready;
`ifdef MUX_ARB_FORCE_EN
   logic               force_en;
   logic [SELW-1:0]    force_sel;
`endif

   arb_mux_n #(.WIDTH(W), .NCH(NCH)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_chan  (out_chan),
      .out_valid (out_valid),
      .out_ready (out_ready)
`ifdef MUX_ARB_FORCE_EN
      ,
      .force_en  (force_en),
      .force_sel (force_sel)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   int           m_ptr;
   logic         m_valid;
   logic [W-1:0] m_data;
   int           m_chan;
   logic [NCH-1:0] last_grant;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Winner is the valid channel at the smallest circular distance after ptr.
   function automatic int rr_winner(input logic [NCH-1:0] v, input int p);
      int best = -1;
      int bestd = NCH;
      for (int i = 0; i < NCH; i++) begin
         int d = (i - p - 1 + 2 * NCH) % NCH;
         if (v[i] && d < bestd) begin
            best  = i;
            bestd = d;
         end
      end
      return best;
   endfunction

   function automatic int pick(output logic is_forced);
      is_forced = 1'b0;
`ifdef MUX_ARB_FORCE_EN
      if (force_en) begin
         is_forced = 1'b1;
         if (int'(force_sel) < NCH && in_valid[force_sel]) return int'(force_sel);
         return -1;
      end
`endif
      return rr_winner(in_valid, m_ptr);
   endfunction

   task automatic model_reset();
      m_ptr = NCH - 1;
      m_valid = 1'b0;
      m_data = '0;
      m_chan = 0;
      last_grant = '0;
   endtask

   // Called just after a rising edge with inputs already applied.
   task automatic step(input string tag);
      int w;
      logic load;
      logic is_forced;
      logic [NCH-1:0] exp_ready;
      load = !m_valid || out_ready;
      w = pick(is_forced);
      if (!load) w = -1;
      exp_ready = '0;
      if (w >= 0) exp_ready[w] = 1'b1;
      #1;
      chk({tag, ".in_ready"}, 32'(in_ready), 32'(exp_ready));
      @(posedge clk);
      if (load) begin
         if (w >= 0) begin
            m_valid = 1'b1;
            m_data  = in_data[w*W +: W];
            m_chan  = w;
            if (!is_forced) m_ptr = w;
         end else begin
            m_valid = 1'b0;
         end
      end
      last_grant = exp_ready;
      #1;
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
      chk({tag, ".out_data"}, 32'(out_data), 32'(m_data));
      chk({tag, ".out_chan"}, 32'(out_chan), 32'(m_chan));
   endtask

   task automatic rand_data();
      for (int i = 0; i < NCH; i++) in_data[i*W +: W] = W'($urandom);
   endtask

   initial begin
      reset = 1'b1;
      in_valid = '1;
      out_ready = 1'b1;
`ifdef MUX_ARB_FORCE_EN
      force_en = 1'b0;
      force_sel = '0;
`endif
      rand_data();
      model_reset();
      #1;
      chk("rst.in_ready", 32'(in_ready), 32'h0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst.out_valid", 32'(out_valid), 32'h0);
      chk("rst.out_data", 32'(out_data), 32'h0);
      chk("rst.out_chan", 32'(out_chan), 32'h0);
      reset = 1'b0;

      // All channels valid: expect 0,1,...,7,0.
      for (int k = 0; k <= NCH; k++) begin
         rand_data();
         step("allvalid");
         chk("allvalid.seq", 32'(out_chan), 32'(k % NCH));
      end

      // Sparse: park ptr at 5, then 2 and 5 alternate.
      in_valid = 8'b0010_0000;
      step("sparse.park");
      in_valid = 8'b0010_0100;
      for (int k = 0; k < 4; k++) begin
         rand_data();
         step("sparse");
         chk("sparse.seq", 32'(out_chan), (k % 2 == 0) ? 32'd2 : 32'd5);
      end

      // Backpressure holding 16'hBEEF from channel 3.
      in_valid = 8'b0000_1000;
      in_data[3*W +: W] = 16'hBEEF;
      step("bp.load");
      in_valid = '1;
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step("bp.hold");
         chk("bp.data", 32'(out_data), 32'hBEEF);
      end
      out_ready = 1'b1;
      step("bp.release");
      chk("bp.next_chan", 32'(out_chan), 32'd4);

      // Idle drains the register but keeps the last word.
      in_valid = '0;
      step("idle");
      chk("idle.out_valid", 32'(out_valid), 32'h0);

      // Asynchronous reset while a word is held.
      in_valid = 8'b0100_0000;
      step("mid.load");
      #2 reset = 1'b1;
      #1;
      chk("mid.out_valid", 32'(out_valid), 32'h0);
      chk("mid.out_data", 32'(out_data), 32'h0);
      chk("mid.in_ready", 32'(in_ready), 32'h0);
      model_reset();
      @(posedge clk);
      #1 reset = 1'b0;
      in_valid = '1;
      step("mid.after");
      chk("mid.first_chan", 32'(out_chan), 32'h0);

`ifdef MUX_ARB_FORCE_EN
      // ptr is 0 here; a forced transfer must not move it.
      force_en = 1'b1;
      force_sel = 3'd6;
      in_valid = 8'b0100_0010;
      step("force.hit");
      chk("force.chan", 32'(out_chan), 32'd6);
      force_en = 1'b0;
      step("force.ptr_kept");
      chk("force.after_chan", 32'(out_chan), 32'd1);
      force_en = 1'b1;
      in_valid = 8'b0000_0010;
      step("force.miss");
      chk("force.miss_valid", 32'(out_valid), 32'h0);
      force_en = 1'b0;
`endif

      // Randomized traffic with producers holding unaccepted words.
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < NCH; i++) begin
            if (!(in_valid[i] && !last_grant[i])) begin
               in_valid[i] = ($urandom_range(0, 1) == 1);
               in_data[i*W +: W] = W'($urandom);
            end
         end
         out_ready = ($urandom_range(0, 3) != 0);
         step("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/arb_mux_n.md
# arb_mux_n

Registered, parametrised N-way, W-bit stream multiplexer for the HACK datapath, generalising the fixed 8-way 16-bit combinational mux. Instead of a static select, it arbitrates round-robin among valid input channels. It presents the winner through a one-entry output register with valid/ready handshake. It sits between multiple producers (e.g. memory-mapped peripherals, ALU result sources) and a single consumer.

## Interface
- WIDTH, 16, data bits per channel
- NCH, 8, number of input channels (>= 2, need not be a power of two)
- SELW, $clog2(NCH), channel index width (derived; do not override)

- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  NCH  channel i has a word
- in_ready  output  NCH  channel i word accepted this cycle (one-hot or zero)
- out_data  output  WIDTH  registered winning word
- out_chan  output  SELW  channel index of out_data
- out_valid  output  1  out_data/out_chan valid
- out_ready  input  1  consumer accepts this cycle
- force_en  input  1  (MUX_ARB_FORCE_EN only) bypass arbitration
- force_sel  input  SELW  (MUX_ARB_FORCE_EN only) forced channel

## Operation
- Clock and reset: one clock `clk`; reset `reset` is asynchronous and active-high.
- load = !out_valid || out_ready; the output register may capture only when load=1.
- Arbitration is round-robin. Search starts at (ptr+1) mod NCH and wraps. The first i with in_valid[i]=1 wins.
- in_ready[i] = load && grant[i]; at most one bit is set, and it is set only for a channel with in_valid=1.
- Transfer on channel i happens when in_valid[i] && in_ready[i]. On the same edge: out_data <= word i, out_chan <= i, out_valid <= 1, ptr <= i.
- If load=1 and no channel is valid, out_valid <= 0. out_data and out_chan hold their previous values.
- If out_valid && !out_ready: out_data and out_chan are stable, all in_ready=0, and ptr is unchanged.
- Producers must hold in_data and in_valid until accepted. The block does not buffer an unaccepted word.
- Index wrap: after ptr=NCH-1, the search begins at 0.

## Timing
- Reset values: out_valid=0, out_data=0, out_chan=0, ptr=NCH-1, so channel 0 has first priority. in_ready is 0 while reset is asserted.
- Latency is 1 cycle from acceptance to out_valid.
- Throughput is one word per cycle when out_ready is held high.
- in_ready is combinational from in_valid, out_valid and out_ready. out_* are purely registered.
- Drain and refill in the same cycle is allowed: out_valid=1 && out_ready=1 with a valid input gives back-to-back words.
- Reset asserted mid-operation discards the held word immediately; there is no flush handshake.

## Configuration
- MUX_ARB_FORCE_EN defined: ports force_en and force_sel exist. With force_en=1, grant goes only to force_sel, and only if in_valid[force_sel]=1; otherwise there is no grant. ptr is not updated on forced transfers. force_sel >= NCH gives no grant.
- MUX_ARB_FORCE_EN undefined: those ports are absent and arbitration is always round-robin.

## Structure
- Shared package hack_mux_pkg holds: the default constants HACK_WORD_W=16 and HACK_MUX_NCH=8, and a chan_idx width helper function.
- One sub-module, rr_arbiter (params NCH): inputs req[NCH], ptr, en; output one-hot grant[NCH] and grant_idx. The update of ptr stays in arb_mux_n.

## Test plan
- Reset check: after reset with all in_valid=1 and out_ready=1, the first word comes from channel 0 one cycle later. Then channels 1,2,…,7,0 follow on consecutive cycles (NCH=8).
- Sparse requests: only channels 2 and 5 valid, ptr=5 → grant 2 then 5 alternately. out_chan sequence is 2,5,2,5.
- Backpressure: out_ready=0 for 4 cycles with out_valid=1, data 16'hBEEF from channel 3 → out_data stays 16'hBEEF, all in_ready=0, ptr stays 3. Releasing out_ready gives the next grant to channel 4 if valid.
- Idle: all in_valid=0 and out_ready=1 → out_valid drops next cycle and out_data holds its last value.
- Reset mid-transfer: assert reset while out_valid=1 → out_valid=0 and out_data=0 immediately. The next grant goes to channel 0.
- With MUX_ARB_FORCE_EN: force_en=1, force_sel=6, channels 1 and 6 valid → only channel 6 granted and ptr unchanged. With force_sel=6 and in_valid[6]=0 → no grant and out_valid=0.
